// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Pipeline boundary register (IF/ID, ID/EX, EX/MEM, MEM/WB or PC) with a
// valid/ready handshake and a one-entry skid buffer. Because in_ready depends
// only on the registered skid flag plus Stall/Flush, the upstream stage never
// waits on out_ready, and one transfer per cycle is still sustained.
// Flush empties the stage and loads the bubble (NOP) encoding. A saturating
// counter records how many cycles the stage presented no valid entry.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   Reset      : synchronous active-high reset, overrides everything
//   Stall      : global hold, freezes stage contents (bubble_cnt still counts)
//   Flush      : synchronous kill of both held entries
//   in_valid   : upstream payload valid
//   in_ready   : stage can accept a payload this cycle
//   in_data    : upstream payload
//   out_valid  : registered, out_data carries a live entry
//   out_ready  : downstream accepts
//   out_data   : registered payload (main entry)
//   occupancy  : number of held entries, 0..2
//   bubble_cnt : saturating count of cycles with out_valid low
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int                 WIDTH      = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]   BUBBLE_VAL = {WIDTH{1'b0}},
  parameter int                 CNT_W      = 16
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   bubble_cnt
);

  // The FSM state is the occupancy itself.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Registered state
  logic [1:0]        r_state;
  logic              r_out_valid;
  logic              r_skid_valid;
  logic [WIDTH-1:0]  r_main;
  logic [WIDTH-1:0]  r_skid;
  logic [CNT_W-1:0]  r_bubble_cnt;

  // Handshake terms
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;

  // Next-state decisions from the transfer FSM
  logic [1:0]        w_state_nxt;
  logic              w_out_valid_nxt;
  logic              w_skid_valid_nxt;
  logic              w_main_ld_in;
  logic              w_main_ld_skid;
  logic              w_skid_ld_in;

  // Handshake: a stalled stage looks not-ready on both sides, so neither
  // fire term can be true while Stall is high.
  always_comb begin
    w_in_ready = ~r_skid_valid & ~Stall & ~Flush;
    w_in_fire  = in_valid & w_in_ready;
    w_out_fire = r_out_valid & out_ready & ~Stall;
  end

  // Next-state logic for the EMPTY / ONE / FULL transfer FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_out_valid_nxt  = r_out_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_main_ld_in     = 1'b0;
    w_main_ld_skid   = 1'b0;
    w_skid_ld_in     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_main_ld_in    = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_ONE;
        end else begin
          w_state_nxt     = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          // Pass-through: the departing entry is replaced in the same edge.
          w_main_ld_in     = 1'b1;
          w_state_nxt      = ST_ONE;
        end else if (w_in_fire) begin
          // Downstream is blocked; park the new payload behind the main one.
          w_skid_ld_in     = 1'b1;
          w_skid_valid_nxt = 1'b1;
          w_state_nxt      = ST_FULL;
        end else if (w_out_fire) begin
          w_out_valid_nxt  = 1'b0;
          w_state_nxt      = ST_EMPTY;
        end else begin
          w_state_nxt      = ST_ONE;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path applies.
        if (w_out_fire) begin
          w_main_ld_skid   = 1'b1;
          w_skid_valid_nxt = 1'b0;
          w_state_nxt      = ST_ONE;
        end else begin
          w_state_nxt      = ST_FULL;
        end
      end
      default: begin
        // Unreachable encoding: fall back to an empty stage.
        w_state_nxt      = ST_EMPTY;
        w_out_valid_nxt  = 1'b0;
        w_skid_valid_nxt = 1'b0;
      end
    endcase
  end

  // State register: Reset, then Flush, then the FSM update.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state      <= ST_EMPTY;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= RESET_VAL;
      r_skid       <= RESET_VAL;
    end else if (Flush) begin
      // Skid payload is left as-is; its valid flag is what matters.
      r_state      <= ST_EMPTY;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= BUBBLE_VAL;
    end else begin
      r_state      <= w_state_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      if (w_main_ld_in) begin
        r_main <= in_data;
      end else if (w_main_ld_skid) begin
        r_main <= r_skid;
      end else begin
        r_main <= r_main;
      end
      if (w_skid_ld_in) begin
        r_skid <= in_data;
      end else begin
        r_skid <= r_skid;
      end
    end
  end

  // Bubble counter: counts edges that start with no valid output, saturates,
  // and survives Flush so mispredict bubbles remain visible.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else if (!r_out_valid && (r_bubble_cnt != CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  // Output drive: everything except in_ready comes straight from flops.
  always_comb begin
    in_ready   = w_in_ready;
    out_valid  = r_out_valid;
    out_data   = r_main;
    occupancy  = r_state;
    bubble_cnt = r_bubble_cnt;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Drives two copies of pipe_stage_skid (16-bit and 3-bit bubble counters) with
// identical stimulus: directed scenarios followed by random traffic. Expected
// values come from a FIFO-queue model of the stage: held entries are a queue
// of at most two payloads, out_data is the queue head (or the last value), and
// the bubble count is an unbounded integer clipped to each counter's maximum.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam logic [31:0] RV = 32'hDEAD_0000;
  localparam logic [31:0] BV = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        Reset, Stall, Flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] bubble_cnt;

  logic        in_ready_c, out_valid_c;
  logic [31:0] out_data_c;
  logic [1:0]  occupancy_c;
  logic [2:0]  bubble_cnt_c;

  pipe_stage_skid #(.WIDTH(32), .RESET_VAL(RV), .BUBBLE_VAL(BV), .CNT_W(16)) dut (
    .clk(clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(.WIDTH(32), .RESET_VAL(RV), .BUBBLE_VAL(BV), .CNT_W(3)) dut_c3 (
    .clk(clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .occupancy(occupancy_c), .bubble_cnt(bubble_cnt_c)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] m_data;
  int          m_bub;
  bit          m_known;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
  task automatic step(input bit rst, input bit st, input bit fl, input bit iv,
                      input logic [31:0] d, input bit ordy);
    bit exp_rdy;
    bit ofire;
    bit ifire;
    @(negedge clk);
    Reset = rst; Stall = st; Flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    exp_rdy = (q.size() < 2) && !st && !fl;
    if (m_known) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("in_ready_c3", {31'd0, in_ready_c}, {31'd0, exp_rdy});
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_data  = RV;
      m_bub   = 0;
      m_known = 1'b1;
    end else begin
      if (q.size() == 0) m_bub++;
      if (fl) begin
        q.delete();
        m_data = BV;
      end else begin
        ofire = (q.size() > 0) && ordy && !st;
        ifire = iv && exp_rdy;
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back(d);
        if (q.size() > 0) m_data = q[0];
      end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
    chk("out_data", out_data, m_data);
    chk("occupancy", {30'd0, occupancy}, q.size());
    chk("bubble_cnt", {16'd0, bubble_cnt}, (m_bub > 65535) ? 65535 : m_bub);
    chk("bubble_cnt_c3", {29'd0, bubble_cnt_c}, (m_bub > 7) ? 7 : m_bub);
    chk("out_data_c3", out_data_c, m_data);
    chk("occupancy_c3", {30'd0, occupancy_c}, q.size());
  endtask

  initial begin
    Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    m_known = 1'b0; m_bub = 0; m_data = RV;

    // Reset wins over Stall
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("reset_data", out_data, 32'hDEAD_0000);

    // Streaming 1..4 with out_ready high, then drain
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, i, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Backpressure: 5, 6 held, then drained in order
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd6, 1'b0);
    chk("bp_full", {30'd0, occupancy}, 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Stall while full holding 7, 8
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd7, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd8, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'hAA, 1'b1);
    chk("stall_hold", out_data, 32'd7);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Flush while full, with 9 offered and Stall high
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd10, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd11, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'd9, 1'b1);
    chk("flush_bubble", out_data, BV);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Counter saturation on the 3-bit instance, kept across Flush, cleared by Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("sat7", {29'd0, bubble_cnt_c}, 32'd7);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("sat7_flush", {29'd0, bubble_cnt_c}, 32'd7);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("cnt_reset", {29'd0, bubble_cnt_c}, 32'd0);

    // Random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(5) == 0), ($urandom_range(15) == 0),
           ($urandom_range(3) != 0), $urandom, $urandom_range(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
